// File: rtl/ceespu_branch_resolver.sv
// In-order queue of predicted branches, resolved against execute outcomes.
// Returns registered predictor updates, and a flush with the corrected PC on a mispredict.
module ceespu_branch_resolver #(
    parameter int DEPTH_LOG2 = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 I_push,
    input  logic [24:0]          I_push_PC,
    input  logic [1:0]           I_push_state,
    input  logic                 I_push_prediction,
    input  logic [24:0]          I_push_target,
    output logic                 O_full,
    output logic                 O_empty,

    input  logic                 I_resolve,
    input  logic                 I_taken,
    input  logic [24:0]          I_target,

    output logic                 O_update_table,
    output logic                 O_branch_taken,
    output logic [15:0]          O_branch_address,
    output logic [1:0]           O_branch_prediction_state,
    output logic                 O_flush,
    output logic [24:0]          O_redirect_PC,
    output logic                 O_error,
    output logic [CNT_WIDTH-1:0] O_branch_count,
    output logic [CNT_WIDTH-1:0] O_mispredict_count
);

    localparam int                   DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]  CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_WIDTH-1:0] STAT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] STAT_ONE  = CNT_WIDTH'(1);

    typedef struct packed {
        logic [24:0] pc;
        logic [1:0]  state;
        logic        pred;
        logic [24:0] target;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic                  update_q;
    logic                  taken_q;
    logic [15:0]           addr_q;
    logic [1:0]            state_q;
    logic                  flush_q;
    logic [24:0]           redirect_q, redirect_d;
    logic                  error_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    entry_t head;
    entry_t push_entry;
    logic   pop;
    logic   resolve_err;
    logic   mispredict;
    logic   push_ok;

    assign O_full  = (count_q == CNT_FULL);
    assign O_empty = (count_q == '0);

    assign head        = mem_q[rptr_q];
    assign push_entry  = '{pc: I_push_PC, state: I_push_state,
                           pred: I_push_prediction, target: I_push_target};
    assign pop         = I_resolve && !O_empty;
    assign resolve_err = I_resolve && O_empty;

    // Target is only meaningful when both predicted and actual direction are taken.
    assign mispredict  = pop && ((I_taken != head.pred) ||
                                 (I_taken && head.pred && (I_target != head.target)));

    // A push during a mispredict is on the wrong path and is dropped.
    assign push_ok     = I_push && !mispredict && (!O_full || pop);

    assign redirect_d  = I_taken ? I_target : (head.pc + 25'd4);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (mispredict) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_ONE;
            if (pop)     rptr_d = rptr_q + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (pop && (branch_cnt_q != STAT_MAX))
            branch_cnt_d = branch_cnt_q + STAT_ONE;
        if (mispredict && (mispred_cnt_q != STAT_MAX))
            mispred_cnt_d = mispred_cnt_q + STAT_ONE;
    end

    // Entry storage needs no reset: a slot is only read once the count covers it.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            update_q      <= 1'b0;
            taken_q       <= 1'b0;
            addr_q        <= '0;
            state_q       <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            error_q       <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            update_q      <= pop;
            flush_q       <= mispredict;
            error_q       <= resolve_err;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (pop) begin
                taken_q <= I_taken;
                addr_q  <= head.pc[15:0];
                state_q <= head.state;
            end
            if (mispredict)
                redirect_q <= redirect_d;
        end
    end

    assign O_update_table            = update_q;
    assign O_branch_taken            = taken_q;
    assign O_branch_address          = addr_q;
    assign O_branch_prediction_state = state_q;
    assign O_flush                   = flush_q;
    assign O_redirect_PC             = redirect_q;
    assign O_error                   = error_q;
    assign O_branch_count            = branch_cnt_q;
    assign O_mispredict_count        = mispred_cnt_q;

endmodule
